f_fetch_ctrl: RTL and testbench

//   Fetch sequencer in front of the F stage. Owns the fetch PC and issues in-order requests to the instruction-memory bus.

---
 rtl/f_fetch_pkg.sv | 25 ++
 rtl/f_fetch_queue.sv | 54 +++++
 rtl/f_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_f_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: reset/exception addresses,
// legal instruction-memory window, FSM states and the queued fetch entry.
package f_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO_DEF  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_DEF  = 32'h0000_6ffc;
    localparam int          Q_DEPTH_DEF  = 2;

    typedef enum logic [1:0] {WAIT, RUN, HALT} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/f_fetch_queue.sv
// Small circular FIFO of fetch entries with synchronous flush and an occupancy count.
// Callers guarantee no push when full and no pop when empty.
module f_fetch_queue
    import f_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [2:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end

endmodule

// File: rtl/f_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues in-order imem requests under a credit limit,
// drops stale responses after redirects and queues {pc, instr, adel} for decode.
// Optional FETCH_TRACE_EN prints every entry handed to decode (simulation only).
module f_fetch_ctrl
    import f_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter logic [31:0] IMEM_LO  = IMEM_LO_DEF,
    parameter logic [31:0] IMEM_HI  = IMEM_HI_DEF,
    parameter int          Q_DEPTH  = Q_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_vld,
    input  logic [31:0] br_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_adel
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [2:0]   outstanding;
    logic [2:0]   drop_cnt;

    logic         redir;
    logic [31:0]  target;
    logic         legal;
    logic         credit_ok;
    logic         req_fire;
    logic         rsp_fire;
    logic         rsp_keep;
    logic         adel_push;
    logic         q_push;
    logic         q_pop;
    fetch_entry_t q_in;
    fetch_entry_t q_head;
    fetch_entry_t pf_in;
    fetch_entry_t pf_head;
    logic [2:0]   q_count;
    logic [2:0]   pf_count;
    logic         unused_pf;

    always_comb begin
        redir  = exc_req | eret | br_vld;
        target = br_pc;
        if (exc_req) begin
            target = EXC_VEC;
        end else if (eret) begin
            target = epc;
        end
    end

    // Credits cover both requests still on the bus and entries waiting for decode.
    assign legal     = addr_legal(pc_q, IMEM_LO, IMEM_HI);
    assign credit_ok = ({1'b0, outstanding} + {1'b0, q_count}) < 4'(Q_DEPTH);

    assign imem_req_valid = (state == RUN) & ~redir & legal & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid;
    assign rsp_keep       = rsp_fire & ~redir & (drop_cnt == 3'd0);
    assign adel_push      = (state == RUN) & ~redir & ~legal & (outstanding == 3'd0)
                          & (q_count < 3'(Q_DEPTH));

    assign f_valid = (q_count != 3'd0) & ~redir;
    assign q_pop   = f_valid & f_ready;
    assign q_push  = rsp_keep | adel_push;
    assign f_pc    = q_head.pc;
    assign f_instr = q_head.instr;
    assign f_adel  = q_head.adel;

    always_comb begin
        q_in = '0;
        if (adel_push) begin
            q_in = '{pc: pc_q, instr: 32'h0, adel: 1'b1};
        end else begin
            q_in = '{pc: pf_head.pc, instr: imem_rsp_data, adel: 1'b0};
        end
    end

    assign pf_in     = '{pc: pc_q, instr: 32'h0, adel: 1'b0};
    assign unused_pf = ^{pf_head.instr, pf_head.adel, pf_count};

    f_fetch_queue #(.DEPTH(Q_DEPTH)) u_out_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redir),
        .head      (q_head),
        .count     (q_count)
    );

    // The PC FIFO is never flushed so it stays aligned with stale responses too.
    f_fetch_queue #(.DEPTH(Q_DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pf_in),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head      (pf_head),
        .count     (pf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT;
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + 3'(req_fire) - 3'(rsp_fire);
            if (redir) begin
                state    <= RUN;
                pc_q     <= target;
                drop_cnt <= outstanding - 3'(rsp_fire);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp_fire && (drop_cnt != 3'd0)) begin
                    drop_cnt <= drop_cnt - 3'd1;
                end
                case (state)
                    WAIT:    state <= RUN;
                    RUN:     if (adel_push) state <= HALT;
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (q_pop) begin
            $display("%d@%h: %h%s", $time, f_pc, f_instr, f_adel ? " AdEL" : "");
        end
    end
`else
`endif

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Self-checking bench for f_fetch_ctrl: a bus model with variable latency, an epoch-based
// scoreboard of the expected fetch stream, and directed redirect/boundary scenarios.
module tb_f_fetch_ctrl;

    localparam int          Q_DEPTH = 2;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        clk;
    logic        rst_n;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        br_vld;
    logic [31:0] br_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_adel;

    f_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_req        (exc_req),
        .eret           (eret),
        .epc            (epc),
        .br_vld         (br_vld),
        .br_pc          (br_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f_valid        (f_valid),
        .f_ready        (f_ready),
        .f_pc           (f_pc),
        .f_instr        (f_instr),
        .f_adel         (f_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } bus_item_t;

    bus_item_t   bus_q[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_instr[$];
    logic        del_adel[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          queued = 0;
    int          del_cnt = 0;
    int          req_cnt = 0;
    int          bus_lat = 1;
    logic        halted = 1'b0;
    logic        run_ok = 1'b0;
    logic [31:0] next_req = 32'h3000;
    logic [31:0] exp_pc = 32'h3000;
    logic        rsp_next = 1'b0;
    logic [31:0] rsp_data_next = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6ffc);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every negedge checks the DUT against the stream model, then advances the
    // model by the handshakes that will complete on the coming rising edge.
    always @(negedge clk) begin
        logic        redir;
        logic [31:0] target;
        logic        exp_req;
        bus_item_t   it;
        if (!rst_n) begin
            bus_q.delete();
            epoch++;
            next_req      = 32'h3000;
            exp_pc        = 32'h3000;
            queued        = 0;
            halted        = 1'b0;
            run_ok        = 1'b0;
            rsp_next      = 1'b0;
            rsp_data_next = 32'h0;
        end else begin
            redir  = exc_req | eret | br_vld;
            target = exc_req ? EXC_VEC : (eret ? epc : br_pc);
            exp_req = run_ok && !redir && is_legal(next_req)
                      && ((bus_q.size() + queued) < Q_DEPTH);
            checkOutput("req_valid", imem_req_valid, exp_req);
            if (imem_req_valid) checkOutput("req_addr", imem_req_addr, next_req);
            if (redir || halted) checkOutput("f_valid_off", f_valid, 0);
            else if (queued > 0) checkOutput("f_valid_on", f_valid, 1);
            else if (is_legal(exp_pc)) checkOutput("f_valid_empty", f_valid, 0);
            if (f_valid && !redir && !halted) begin
                checkOutput("f_pc", f_pc, exp_pc);
                checkOutput("f_adel", f_adel, !is_legal(exp_pc));
                checkOutput("f_instr", f_instr, is_legal(exp_pc) ? instr_of(exp_pc) : 32'h0);
            end

            if (imem_rsp_valid && bus_q.size() > 0) begin
                it = bus_q.pop_front();
                if (it.ep == epoch && !redir) queued++;
            end
            if (redir) begin
                epoch++;
                next_req = target;
                exp_pc   = target;
                queued   = 0;
                halted   = 1'b0;
            end else begin
                if (f_valid && f_ready) begin
                    del_pc.push_back(f_pc);
                    del_instr.push_back(f_instr);
                    del_adel.push_back(f_adel);
                    del_cnt++;
                    if (f_adel) halted = 1'b1;
                    else if (queued > 0) queued--;
                    exp_pc = exp_pc + 32'd4;
                end
                if (imem_req_valid && imem_req_ready) begin
                    bus_q.push_back('{addr: imem_req_addr, ep: epoch, due: cyc + bus_lat});
                    next_req = next_req + 32'd4;
                    req_cnt++;
                end
            end
            run_ok        = 1'b1;
            rsp_next      = (bus_q.size() > 0) && (bus_q[0].due <= cyc + 1);
            rsp_data_next = rsp_next ? instr_of(bus_q[0].addr) : 32'h0;
            cyc++;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = rsp_next;
        imem_rsp_data  = rsp_data_next;
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic exc, input logic er, input logic [31:0] ep,
                                 input logic br, input logic [31:0] bp);
        exc_req = exc;
        eret    = er;
        epc     = ep;
        br_vld  = br;
        br_pc   = bp;
        stepCycles(1);
        exc_req = 1'b0;
        eret    = 1'b0;
        br_vld  = 1'b0;
    endtask

    task automatic waitDeliveries(input int target_cnt, input int budget);
        int n = 0;
        while (del_cnt < target_cnt && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput("deliv_timeout", 32'(del_cnt >= target_cnt), 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int r0;
        int n;
        rst_n = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = '0; br_vld = 1'b0; br_pc = '0;
        imem_req_ready = 1'b1; f_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stepCycles(3);
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_f_valid", f_valid, 0);
        checkOutput("rst_f_pc", f_pc, 0);
        checkOutput("rst_f_instr", f_instr, 0);
        checkOutput("rst_f_adel", f_adel, 0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("wait_no_req", imem_req_valid, 0);
        @(negedge clk);
        checkOutput("first_req_valid", imem_req_valid, 1);
        checkOutput("first_req_addr", imem_req_addr, 32'h3000);
        stepCycles(1);
        waitDeliveries(3, 30);
        checkOutput("seq_pc0", del_pc[0], 32'h3000);
        checkOutput("seq_pc1", del_pc[1], 32'h3004);
        checkOutput("seq_pc2", del_pc[2], 32'h3008);
        checkOutput("seq_instr0", del_instr[0], 32'hcfff_3000);

        // Decode stall: credits fill up, then the stream resumes in order.
        f_ready = 1'b0;
        base = del_cnt;
        stepCycles(10);
        checkOutput("stall_req_off", imem_req_valid, 0);
        checkOutput("stall_f_valid", f_valid, 1);
        checkOutput("stall_no_pop", 32'(del_cnt - base), 0);
        f_ready = 1'b1;
        waitDeliveries(base + 4, 40);

        imem_req_ready = 1'b0;
        stepCycles(3);
        imem_req_ready = 1'b1;
        waitDeliveries(del_cnt + 2, 30);

        // Branch with two requests in flight on a slower bus.
        bus_lat = 3;
        n = 0;
        while (bus_q.size() != 2 && n < 20) begin
            stepCycles(1);
            n++;
        end
        checkOutput("two_in_flight", 32'(bus_q.size()), 2);
        base = del_cnt;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h3100);
        waitDeliveries(base + 2, 60);
        checkOutput("br_pc0", del_pc[base], 32'h3100);
        checkOutput("br_instr0", del_instr[base], 32'hceff_3100);
        checkOutput("br_pc1", del_pc[base + 1], 32'h3104);
        bus_lat = 1;

        base = del_cnt;
        applyStimulus(1'b1, 1'b1, 32'h3040, 1'b1, 32'h3100);
        waitDeliveries(base + 2, 40);
        checkOutput("prio_pc0", del_pc[base], 32'h4180);
        checkOutput("prio_pc1", del_pc[base + 1], 32'h4184);

        // Misaligned eret target: a single AdEL entry and no bus traffic afterwards.
        base = del_cnt;
        applyStimulus(1'b0, 1'b1, 32'h3002, 1'b0, 32'h0);
        waitDeliveries(base + 1, 40);
        checkOutput("adel_pc", del_pc[base], 32'h3002);
        checkOutput("adel_flag", 32'(del_adel[base]), 1);
        checkOutput("adel_instr", del_instr[base], 32'h0);
        r0 = req_cnt;
        stepCycles(10);
        checkOutput("halt_no_req", 32'(req_cnt - r0), 0);
        checkOutput("halt_no_entry", 32'(del_cnt - base), 1);

        base = del_cnt;
        r0 = req_cnt;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h6ff8);
        waitDeliveries(base + 3, 40);
        checkOutput("top_pc0", del_pc[base], 32'h6ff8);
        checkOutput("top_instr0", del_instr[base], 32'h9007_6ff8);
        checkOutput("top_pc1", del_pc[base + 1], 32'h6ffc);
        checkOutput("top_pc2", del_pc[base + 2], 32'h7000);
        checkOutput("top_adel2", 32'(del_adel[base + 2]), 1);
        stepCycles(10);
        checkOutput("top_req_total", 32'(req_cnt - r0), 2);
        checkOutput("top_halt_f_valid", f_valid, 0);

        // Reset in the middle of traffic restarts from the reset PC.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h3200);
        stepCycles(4);
        rst_n = 1'b0;
        stepCycles(2);
        checkOutput("mid_rst_req", imem_req_valid, 0);
        checkOutput("mid_rst_f_valid", f_valid, 0);
        checkOutput("mid_rst_f_pc", f_pc, 0);
        checkOutput("mid_rst_f_instr", f_instr, 0);
        rst_n = 1'b1;
        base = del_cnt;
        waitDeliveries(base + 1, 30);
        checkOutput("mid_rst_pc0", del_pc[base], 32'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
